// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared CPU constants (datapath width, divider FSM states, instruction types)
package seq_divider_pkg;
  localparam int DIV_W = 32;
  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;
  typedef enum logic [2:0] {
    INST_TYPE_R,
    INST_TYPE_I,
    INST_TYPE_J,
    INST_TYPE_MUL,
    INST_TYPE_DIV
  } inst_type_e;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand request and result bundle between controller and divider
interface seq_divider_if #(parameter int DIV_W = seq_divider_pkg::DIV_W);
  logic             div_start;
  logic             div_signed;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] q;
  logic [DIV_W-1:0] r;
  logic             div_zero;
  modport master (
    output div_start, div_signed, dividend, divisor,
    input  div_busy, div_done, q, r, div_zero
  );
  modport slave (
    input  div_start, div_signed, dividend, divisor,
    output div_busy, div_done, q, r, div_zero
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring shift-subtract iteration on unsigned magnitudes
module div_step #(parameter int DIV_W = seq_divider_pkg::DIV_W) (
  input  logic [DIV_W:0]   rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] den,
  output logic [DIV_W:0]   rem_n,
  output logic [DIV_W-1:0] quo_n
);
  logic [DIV_W+1:0] sh;
  logic [DIV_W+1:0] diff;
  always_comb begin
    sh    = {rem, quo[DIV_W-1]};
    diff  = sh - {2'b00, den};
    rem_n = diff[DIV_W+1] ? sh[DIV_W:0] : diff[DIV_W:0];
    quo_n = {quo[DIV_W-2:0], ~diff[DIV_W+1]};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: fixed-latency signed/unsigned restoring divider (DIV/DIVU), 34 cycles per result
module seq_divider #(parameter int DIV_W = seq_divider_pkg::DIV_W) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);
  import seq_divider_pkg::*;
  localparam int CNT_W = $clog2(DIV_W);
  div_state_e       st;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W:0]   rem;
  logic [DIV_W:0]   rem_n;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] quo_n;
  logic [DIV_W-1:0] den;
  logic             qs;
  logic             rs;
  logic             a_neg;
  logic             b_neg;
  assign a_neg = bus.div_signed & bus.dividend[DIV_W-1];
  assign b_neg = bus.div_signed & bus.divisor[DIV_W-1];
  div_step #(.DIV_W(DIV_W)) u_step (
    .rem   (rem),
    .quo   (quo),
    .den   (den),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st           <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      den          <= '0;
      qs           <= 1'b0;
      rs           <= 1'b0;
      bus.div_busy <= 1'b0;
      bus.div_done <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.q        <= '0;
      bus.r        <= '0;
    end else begin
      bus.div_done <= 1'b0;
      case (st)
        IDLE: if (bus.div_start) begin
          st           <= CALC;
          cnt          <= '0;
          rem          <= '0;
          quo          <= a_neg ? -bus.dividend : bus.dividend;
          den          <= b_neg ? -bus.divisor : bus.divisor;
          qs           <= a_neg ^ b_neg;
          rs           <= a_neg;
          bus.div_busy <= 1'b1;
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          st  <= (cnt == CNT_W'(DIV_W - 1)) ? FIX : CALC;
        end
        FIX: begin
          st           <= IDLE;
          bus.div_busy <= 1'b0;
          bus.div_done <= 1'b1;
          bus.div_zero <= (den == '0);
          bus.q        <= (den == '0) ? '1 : (qs ? -quo : quo);
          bus.r        <= rs ? -rem[DIV_W-1:0] : rem[DIV_W-1:0];
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic reference model
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  seq_divider_if #(.DIV_W(32)) bus ();
  seq_divider #(.DIV_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_zero = 1'b0;
  logic [31:0] m_q = '0;
  logic [31:0] m_r = '0;
  logic [63:0] p_res = '0;
  logic        p_zero = 1'b0;
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    return {qq[31:0], rr[31:0]};
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_zero = 1'b0;
      m_q    = '0;
      m_r    = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done     = 1'b1;
          {m_q, m_r} = p_res;
          m_zero     = p_zero;
        end
      end else if (bus.div_start) begin
        m_left = 33;
        p_res  = ref_div(bus.div_signed, bus.dividend, bus.divisor);
        p_zero = (bus.divisor == 0);
      end
    end
  always @(negedge clk) begin
    checks++;
    if ({bus.div_busy, bus.div_done, bus.div_zero, bus.q, bus.r} !==
        {m_left > 0, m_done, m_zero, m_q, m_r}) begin
      errors++;
      $display("FAIL model t=%0t busy/done/zero/q/r got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h", $time,
               bus.div_busy, bus.div_done, bus.div_zero, bus.q, bus.r, m_left > 0, m_done, m_zero, m_q, m_r);
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b, input int inj,
                     output int k, output int bc);
    bus.div_start  = 1'b1;
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    k  = 0;
    bc = 0;
    do begin
      @(negedge clk);
      k++;
      bus.div_start  = (k == inj);
      bus.div_signed = 1'($urandom);
      bus.dividend   = $urandom;
      bus.divisor    = $urandom;
      if (bus.div_busy) bc++;
    end while (!bus.div_done && k < 60);
  endtask
  task automatic expect_div(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er, input bit ez, input int inj);
    int k, bc;
    run(s, a, b, inj, k, bc);
    chk({name, " latency"}, 64'(k), 64'd34);
    chk({name, " busy cycles"}, 64'(bc), 64'd33);
    chk({name, " q"}, 64'(bus.q), 64'(eq));
    chk({name, " r"}, 64'(bus.r), 64'(er));
    chk({name, " zero"}, 64'(bus.div_zero), 64'(ez));
  endtask
  initial begin
    int k, bc;
    logic [31:0] a, b;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {bus.div_busy, bus.div_done, bus.div_zero, bus.q, bus.r}, '0);
    rst = 1'b1;
    @(negedge clk);
    expect_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    @(negedge clk);
    chk("done one cycle", 64'(bus.div_done), 64'd0);
    expect_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    expect_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
    expect_div("u/0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
    expect_div("s/0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
    expect_div("s/0 neg", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1, 0);
    expect_div("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);
    expect_div("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    expect_div("ignored start", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 10);
    expect_div("b2b start", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("abort outputs", {bus.div_busy, bus.div_done, bus.div_zero, bus.q, bus.r}, '0);
    @(negedge clk);
    @(negedge clk);
    chk("abort no done", {bus.div_busy, bus.div_done, bus.q, bus.r}, '0);
    rst = 1'b1;
    expect_div("after rst 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);
    repeat (1500) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = $urandom_range(1, 16);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 1000) * (($urandom_range(0, 1) == 1) ? -1 : 1); end
        default: ;
      endcase
      bus.div_start  = ($urandom_range(0, 3) == 0);
      bus.div_signed = 1'($urandom);
      bus.dividend   = a;
      bus.divisor    = b;
    end
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
